timer_sched: RTL and testbench

//  Shares one timer instance between NUM_REQ requesters (pulse measurement or delay).

---
 rtl/timer_sched_pkg.sv | 20 ++
 rtl/timer_sched_rr_arbiter.sv | 38 +++
 rtl/timer_sched.sv | 176 +++++++++++++++++
 tb/tb_timer_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: values shared by the timer scheduler.
//   MODE_*        : encodings driven onto the shared timer's mode port
//   REQ_*         : encodings of a requester's req_mode bit
//   state_e       : scheduler FSM states
package timer_sched_pkg;

    localparam logic MODE_TIMER            = 1'b0;
    localparam logic MODE_COUNT_DOWN_TIMER = 1'b1;

    localparam logic REQ_MEASURE = 1'b0;
    localparam logic REQ_DELAY   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/timer_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req   : request vector
//   ptr   : index with highest priority this round
//   grant : one-hot winner (zero when no request)
//   idx   : binary index of the winner
//   valid : at least one request present
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_sched.sv
// timer_sched: shares one external timer between NUM_REQ requesters.
//   clk, rst               : clock, synchronous active-high reset
//   req/req_mode/req_value : level requests, mode (0 measure, 1 delay), delay ticks
//   meas_in                : per-requester pulse to be measured
//   grant/done/result/err  : owner, completion pulse, captured counter, timeout flag
//   timer_*                : control/status of the shared timer instance
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_mode,
    input  logic [64*NUM_REQ-1:0]  req_value,
    input  logic [NUM_REQ-1:0]     meas_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [63:0]            result,
    output logic                   err,
    output logic                   timer_rst,
    output logic                   timer_enable,
    output logic                   timer_mode,
    output logic                   timer_count_once,
    output logic [63:0]            timer_count_down_value,
    input  logic [63:0]            timer_counter,
    input  logic                   timer_delay_pending
);

    localparam int unsigned IDX_W       = $clog2(NUM_REQ);
    localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [63:0]        result_q, result_d;
    logic               err_q, err_d;
    logic               meas_prev_q, meas_prev_d;
    logic [31:0]        run_cnt_q, run_cnt_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [63:0] value_arr [NUM_REQ];
    logic        sel_req, sel_mode, sel_meas, active, running;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_val
        assign value_arr[g] = req_value[64*g +: 64];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_req  = req[sel_q];
    assign sel_mode = req_mode[sel_q];
    assign sel_meas = meas_in[sel_q];
    assign active   = (state_q != ST_IDLE);
    assign running  = (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        done_d      = '0;
        result_d    = result_q;
        err_d       = 1'b0;
        meas_prev_d = meas_prev_q;
        run_cnt_d   = run_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d = ST_LOAD;
                    sel_d   = arb_idx;
                    grant_d = arb_grant;
                    ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_LOAD: begin
                meas_prev_d = 1'b0;
                run_cnt_d   = '0;
                if (!sel_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                meas_prev_d = sel_meas;
                if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + 32'd1;
                end
                if (!sel_req) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (sel_mode == REQ_DELAY) begin
                    if (!timer_delay_pending) begin
                        state_d  = ST_DONE;
                        done_d   = grant_q;
                        result_d = timer_counter;
                    end
                end else if (meas_prev_q && !sel_meas) begin
                    state_d  = ST_DONE;
                    done_d   = grant_q;
                    result_d = timer_counter;
                end else if (run_cnt_d >= TIMEOUT_LIM) begin
                    // run_cnt_d already includes this cycle, so the abort
                    // lands on the TIMEOUT_CYCLES-th RUN cycle.
                    state_d  = ST_DONE;
                    done_d   = grant_q;
                    result_d = timer_counter;
                    err_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            meas_prev_q <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
            meas_prev_q <= meas_prev_d;
            run_cnt_q   <= run_cnt_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

    // Enable drops combinationally on an owner abort or a reset request so
    // the timer never advances in the cycle the operation is being torn down.
    assign timer_rst              = rst || (state_q == ST_LOAD);
    assign timer_enable           = running && sel_req && !rst &&
                                    ((sel_mode == REQ_DELAY) || sel_meas);
    assign timer_count_once       = running && !rst && (sel_mode == REQ_MEASURE);
    assign timer_mode             = (active && sel_mode == REQ_DELAY) ?
                                    MODE_COUNT_DOWN_TIMER : MODE_TIMER;
    assign timer_count_down_value = active ? value_arr[sel_q] : '0;

endmodule

// File: tb/tb_timer_sched.sv
module tb_timer_sched;

    logic         clk;
    logic         rst;
    logic [3:0]   req, req_mode, meas_in;
    logic [255:0] req_value;
    logic [3:0]   grant, done;
    logic [63:0]  result;
    logic         err;
    logic         timer_rst, timer_enable, timer_mode, timer_count_once;
    logic [63:0]  timer_count_down_value, timer_counter;
    logic         timer_delay_pending;

    logic [63:0]  val [4];
    logic [63:0]  tcnt;
    int           cyc;
    int           n_checks;
    int           n_fail;
    int           s;

    typedef struct {
        int          idx;
        logic [63:0] res;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    exp_t e;

    assign req_value = {val[3], val[2], val[1], val[0]};

    timer_sched #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req                    (req),
        .req_mode               (req_mode),
        .req_value              (req_value),
        .meas_in                (meas_in),
        .grant                  (grant),
        .done                   (done),
        .result                 (result),
        .err                    (err),
        .timer_rst              (timer_rst),
        .timer_enable           (timer_enable),
        .timer_mode             (timer_mode),
        .timer_count_once       (timer_count_once),
        .timer_count_down_value (timer_count_down_value),
        .timer_counter          (timer_counter),
        .timer_delay_pending    (timer_delay_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the shared timer.
    always @(posedge clk) begin
        if (timer_rst)
            tcnt <= timer_mode ? timer_count_down_value : 64'd0;
        else if (timer_enable) begin
            if (timer_mode) tcnt <= (tcnt != 64'd0) ? tcnt - 64'd1 : 64'd0;
            else            tcnt <= tcnt + 64'd1;
        end
    end
    assign timer_counter       = tcnt;
    assign timer_delay_pending = timer_mode && (tcnt != 64'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] i, input logic m, input logic [63:0] v);
        req_mode[i] = m;
        val[i]      = v;
        req[i]      = 1'b1;
    endtask

    task automatic push(input int idx, input logic [63:0] res, input logic er, input int c);
        exp_t x;
        x.idx = idx;
        x.res = res;
        x.err = er;
        x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic wait_done(input logic [1:0] idx, input int limit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (done[idx]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done[%0d] within %0d cycles, expected one", idx, limit);
        end
    endtask

    // Scoreboard monitor: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (done !== 4'b0000) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: done=%b at cycle %0d, expected no completion", done, cyc);
            end else begin
                e = sb.pop_front();
                chk("done_vec",   64'(done),  64'(4'b0001 << e.idx));
                chk("result",     result,     e.res);
                chk("err",        64'(err),   64'(e.err));
                chk("done_cycle", 64'(cyc),   64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        req_mode = '0;
        meas_in  = '0;
        for (int i = 0; i < 4; i++) val[i] = '0;

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_grant",     64'(grant),        64'd0);
        chk("rst_done",      64'(done),         64'd0);
        chk("rst_result",    result,            64'd0);
        chk("rst_err",       64'(err),          64'd0);
        chk("rst_enable",    64'(timer_enable), 64'd0);
        chk("rst_timer_rst", 64'(timer_rst),    64'd1);
        step(1);
        rst = 1'b0;

        // 1: delay of 5 on requester 0
        step(1);
        s = cyc;
        set_req(2'd0, 1'b1, 64'd5);
        push(0, 64'd0, 1'b0, s + 8);
        @(negedge clk);
        @(negedge clk);
        chk("t1_grant",     64'(grant),        64'b0001);
        chk("t1_timer_rst", 64'(timer_rst),    64'd1);
        chk("t1_enable",    64'(timer_enable), 64'd0);
        chk("t1_mode",      64'(timer_mode),   64'd1);
        chk("t1_cdv",       timer_count_down_value, 64'd5);
        wait_done(2'd0, 40);
        req[0] = 1'b0;

        // 2: zero delay
        step(1);
        s = cyc;
        set_req(2'd0, 1'b1, 64'd0);
        push(0, 64'd0, 1'b0, s + 3);
        wait_done(2'd0, 20);
        req[0] = 1'b0;

        // 3: measure 17-cycle pulse on requester 1, second pulse ignored
        step(1);
        s = cyc;
        set_req(2'd1, 1'b0, 64'd0);
        push(1, 64'd17, 1'b0, s + 21);
        step(3);
        meas_in[1] = 1'b1;
        step(17);
        meas_in[1] = 1'b0;
        step(1);
        meas_in[1] = 1'b1;
        wait_done(2'd1, 10);
        req[1] = 1'b0;
        step(3);
        meas_in[1] = 1'b0;

        // 5: abort requester 2 mid-RUN, then requester 3 served normally
        step(1);
        s = cyc;
        set_req(2'd2, 1'b1, 64'd20);
        step(5);
        req[2] = 1'b0;
        @(negedge clk);
        chk("abort_enable", 64'(timer_enable), 64'd0);
        chk("abort_grant_held", 64'(grant),    64'b0100);
        @(negedge clk);
        chk("abort_grant",  64'(grant),        64'd0);
        chk("abort_cdv",    timer_count_down_value, 64'd0);
        chk("abort_result", result,            64'd17);
        step(1);
        s = cyc;
        set_req(2'd3, 1'b1, 64'd1);
        push(3, 64'd0, 1'b0, s + 4);
        wait_done(2'd3, 20);
        req[3] = 1'b0;

        // Reset between phases so the round-robin pointer restarts at 0
        step(1);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("rst2_grant", 64'(grant), 64'd0);
        step(1);
        rst = 1'b0;

        // 4: round-robin, all requesting delays of 2
        step(1);
        s = cyc;
        for (int i = 0; i < 4; i++) set_req(2'(i), 1'b1, 64'd2);
        for (int k = 0; k < 5; k++) push(k % 4, 64'd0, 1'b0, s + 6 * k + 5);
        for (int k = 0; k < 5; k++) wait_done(2'(k % 4), 20);
        req = '0;

        // 6a: timeout, pulse already high at RUN start and never falls
        step(1);
        s = cyc;
        meas_in[0] = 1'b1;
        set_req(2'd0, 1'b0, 64'd0);
        push(0, 64'd49, 1'b1, s + 52);
        wait_done(2'd0, 80);
        req[0]     = 1'b0;
        meas_in[0] = 1'b0;

        // 6b: reset mid-RUN
        step(1);
        s = cyc;
        set_req(2'd1, 1'b1, 64'd30);
        step(5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_timer_rst", 64'(timer_rst),    64'd1);
        chk("midrst_enable0",   64'(timer_enable), 64'd0);
        step(1);
        @(negedge clk);
        chk("midrst_grant",  64'(grant),        64'd0);
        chk("midrst_done",   64'(done),         64'd0);
        chk("midrst_err",    64'(err),          64'd0);
        chk("midrst_result", result,            64'd0);
        chk("midrst_enable", 64'(timer_enable), 64'd0);
        chk("midrst_trst",   64'(timer_rst),    64'd1);
        chk("midrst_mode",   64'(timer_mode),   64'd0);
        req[1] = 1'b0;
        step(1);
        rst = 1'b0;
        step(5);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
